// File: rtl/axi_dma_rd_engine.sv
// axi_dma_rd_engine
// AXI4 read master for the DMA read path. A one-cycle command (start address,
// beat count) is split into INCR bursts that never exceed MAX_BURST beats and
// never cross a 4 KB boundary. Only one burst is outstanding at a time. R data
// is passed straight through to the buffer with ready/valid backpressure, and
// a one-cycle done pulse is returned when the last beat has been accepted.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   i_ctrl_read/i_read_addr/i_num_trans   command pulse, start address, beats
//   o_arvalid/i_arready/o_araddr/o_arlen/o_arsize/o_arburst   AR channel
//   i_rvalid/o_rready/i_rdata/i_rlast/i_rresp                  R channel
//   o_data/o_data_vld/i_data_ready  beat stream towards the buffer
//   o_read_done                     one-cycle completion pulse
//   o_busy                          command in progress
//   o_err                           sticky error for the current command
module axi_dma_rd_engine #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int BIT_TRANS    = 18,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_ctrl_read,
  input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
  input  logic [BIT_TRANS-1:0]    i_num_trans,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [AXI_WIDTH_AD-1:0] o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [AXI_WIDTH_DA-1:0] i_rdata,
  input  logic                    i_rlast,
  input  logic [1:0]              i_rresp,
  output logic [AXI_WIDTH_DA-1:0] o_data,
  output logic                    o_data_vld,
  input  logic                    i_data_ready,
  output logic                    o_read_done,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int BYTES = AXI_WIDTH_DA / 8;
  localparam int SIZE  = $clog2(BYTES);
  // Common width for comparing remaining beats against 4 KB / MAX_BURST limits.
  localparam int CW    = (BIT_TRANS > 13) ? BIT_TRANS : 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [AXI_WIDTH_AD-1:0] addr;       // address of the next burst to issue
  logic [BIT_TRANS-1:0]    remaining;  // beats not yet requested on AR
  logic [8:0]              len;        // beats in the burst in flight (1..256)
  logic [8:0]              beat_cnt;   // beats accepted in the current burst
  logic [8:0]              next_len;
  logic                    beat;
  logic                    last_beat;

  // Burst length = min(remaining, MAX_BURST, beats left before the 4 KB page end).
  function automatic logic [8:0] calc_len(input logic [AXI_WIDTH_AD-1:0] a,
                                          input logic [BIT_TRANS-1:0]    rem);
    logic [CW-1:0] to_page;
    logic [CW-1:0] cap;
    logic [CW-1:0] l;
    to_page = CW'((13'h1000 - {1'b0, a[11:0]}) >> SIZE);
    cap     = CW'(MAX_BURST);
    l       = CW'(rem);
    if (to_page < l) l = to_page;
    if (cap < l)     l = cap;
    return l[8:0];
  endfunction

  // Next burst length: from the incoming command in IDLE, else from the running counters.
  always_comb begin
    next_len = 9'd0;
    if (state == ST_IDLE) begin
      next_len = calc_len(i_read_addr, i_num_trans);
    end else begin
      next_len = calc_len(addr, remaining);
    end
  end

  // Beat acceptance; the burst end is decided by our own count, never by i_rlast.
  always_comb begin
    beat      = (state == ST_R) && i_rvalid && i_data_ready;
    last_beat = ((beat_cnt + 9'd1) == len);
  end

  assign o_rready   = (state == ST_R) && i_data_ready;
  assign o_data_vld = (state == ST_R) && i_rvalid;
  assign o_data     = i_rdata;
  assign o_arsize   = 3'(SIZE);
  assign o_arburst  = 2'b01;

  // Command FSM with registered AR channel, done pulse, busy and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      len         <= 9'd0;
      beat_cnt    <= 9'd0;
      o_arvalid   <= 1'b0;
      o_araddr    <= '0;
      o_arlen     <= 8'd0;
      o_read_done <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_read_done <= 1'b0;
          if (i_ctrl_read) begin
            o_err     <= 1'b0;
            o_busy    <= 1'b1;
            beat_cnt  <= 9'd0;
            addr      <= i_read_addr;
            remaining <= i_num_trans;
            if (i_num_trans == '0) begin
              state       <= ST_DONE;
              o_read_done <= 1'b1;
            end else begin
              state     <= ST_AR;
              o_arvalid <= 1'b1;
              o_araddr  <= i_read_addr;
              o_arlen   <= 8'(next_len - 9'd1);
              len       <= next_len;
            end
          end
        end
        ST_AR: begin
          // araddr/arlen stay untouched until the slave takes them.
          if (i_arready) begin
            o_arvalid <= 1'b0;
            state     <= ST_R;
            addr      <= addr + (AXI_WIDTH_AD'(len) << SIZE);
            remaining <= remaining - BIT_TRANS'(len);
          end
        end
        ST_R: begin
          if (beat) begin
            if ((i_rresp != 2'b00) || (i_rlast != last_beat)) begin
              o_err <= 1'b1;
            end
            if (last_beat) begin
              beat_cnt <= 9'd0;
              if (remaining != '0) begin
                state     <= ST_AR;
                o_arvalid <= 1'b1;
                o_araddr  <= addr;
                o_arlen   <= 8'(next_len - 9'd1);
                len       <= next_len;
              end else begin
                state       <= ST_DONE;
                o_read_done <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        ST_DONE: begin
          o_read_done <= 1'b0;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          o_arvalid   <= 1'b0;
          o_read_done <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_dma_rd_engine.md
# axi_dma_rd_engine

AXI4 read master that sits directly downstream of the DMA read controller. It accepts a one-cycle read command (start address plus beat count) and splits it into INCR bursts on the AR channel. It streams R-channel data to the feature/weight buffer with ready/valid backpressure, then returns a one-cycle read-done pulse that the controller uses to advance its block index.

## Interface
Parameters:
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width (bytes per beat = AXI_WIDTH_DA/8)
- BIT_TRANS, 18, beat-count width
- MAX_BURST, 16, max beats per burst (1..256)

Ports:
- clk  in  1  clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- i_ctrl_read  in  1  command pulse
- i_read_addr  in  AXI_WIDTH_AD  start byte address, beat-aligned
- i_num_trans  in  BIT_TRANS  total beats
- o_arvalid / i_arready  out/in  1  AR handshake
- o_araddr  out  AXI_WIDTH_AD  burst address
- o_arlen  out  8  beats-1
- o_arsize  out  3  log2(AXI_WIDTH_DA/8), constant
- o_arburst  out  2  constant 2'b01 (INCR)
- i_rvalid / o_rready  in/out  1  R handshake
- i_rdata  in  AXI_WIDTH_DA  read data
- i_rlast  in  1  last beat of burst
- i_rresp  in  2  response
- o_data  out  AXI_WIDTH_DA  = i_rdata
- o_data_vld  out  1  beat valid to buffer
- i_data_ready  in  1  buffer can accept
- o_read_done  out  1  one-cycle completion pulse
- o_busy  out  1  command in progress
- o_err  out  1  sticky error for current command

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: on i_ctrl_read, latch addr/num_trans and clear o_err.
  - num_trans==0 -> DONE.
  - Otherwise -> AR.
  - i_ctrl_read while not IDLE is ignored.
- AR: o_arvalid=1, with araddr/arlen registered and stable until i_arready. On handshake -> R.
- Burst length = min(remaining, MAX_BURST, beats to next 4 KB boundary), where beats to boundary = (4096 - addr[11:0]) / bytes-per-beat.
  - o_arlen = len-1.
  - After the AR handshake: addr += len*bytes, remaining -= len.
- R: o_rready = i_data_ready; o_data_vld = i_rvalid; o_data = i_rdata. These are combinational, zero latency.
  - A beat counts when i_rvalid && i_data_ready.
  - On the counted beat that ends the burst (beat count == len): remaining>0 -> AR; remaining==0 -> DONE.
- Errors (sticky, set o_err, transfer continues):
  - i_rresp != 0 on any counted beat.
  - i_rlast mismatching the expected last beat.
  - Burst end is set by the internal count, not by i_rlast.
- DONE: o_read_done=1 for one cycle -> IDLE.
- o_busy = (state != IDLE).
- One outstanding burst only; no AR issue during R.

## Timing
- Reset: state IDLE, counters 0. o_arvalid, o_rready, o_data_vld, o_read_done, o_busy, o_err, o_araddr, o_arlen = 0. o_arsize/o_arburst hold their constants.
- i_ctrl_read at cycle T -> o_arvalid=1 at T+1.
- AR handshake at cycle A -> o_rready may assert at A+1.
- Last beat accepted at cycle L:
  - Next burst's o_arvalid at L+1.
  - If final, o_read_done at L+1, o_busy=0 at L+2.
- num_trans==0: o_read_done at T+1.
- Next command accepted at earliest the cycle after o_read_done.
- o_arvalid never drops before i_arready; o_araddr/o_arlen stable while o_arvalid && !i_arready.
- Reset assertion mid-command aborts immediately to the reset values; any in-flight R beats after reset are not accepted (o_rready=0).
- o_err holds until the next accepted i_ctrl_read.

## Test plan
- addr 0x1000, num 16, i_arready=1, i_rvalid every cycle -> single AR (araddr 0x1000, arlen 15), 16 beats out in order, o_read_done one cycle after beat 16, o_err=0.
- addr 0x2000, num 40 -> ARs 0x2000/len15, 0x2040/len15, 0x2080/len7; 40 beats; exactly one done pulse.
- addr 0x0FF0, num 16 -> AR 0x0FF0/arlen 3, then 0x1000/arlen 11; no burst crosses 4 KB.
- i_arready delayed 5 cycles, i_data_ready toggling 1010..., num 20 -> araddr/arlen stable while stalled; o_rready tracks i_data_ready; exactly 20 beats counted, data matches memory model.
- num 16 with i_rresp=2'b10 on beat 3 and i_rlast on beat 10 -> o_err=1, done still pulses after 16 beats; next command clears o_err; num 0 command -> done at T+1, no AR issued.
- rstn low mid-burst (beat 5 of 16) -> all outputs reset values within the same cycle; after release, command addr 0x3000 num 4 completes normally.
